// File: rtl/matmul_sequencer.sv
// matmul_sequencer: runs one MATMUL on the systolic array for each accepted command.
// It preloads an N-row weight tile into the weight FIFO, pulses the array start,
// streams the activation rows out of the unified buffer, waits for the array's
// completion and then pulses done.
module matmul_sequencer #(
  parameter int ADDR_W = 8,
  parameter int N      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_ub_addr,
  input  logic [ADDR_W-1:0] cmd_wt_addr,
  input  logic [7:0]        cmd_rows,
  output logic [ADDR_W-1:0] wt_rd_addr,
  output logic              wt_fifo_wr,
  input  logic              wt_fifo_full,
  output logic              sys_start,
  output logic [7:0]        sys_rows,
  output logic              ub_rd_en,
  output logic [ADDR_W-1:0] ub_rd_addr,
  input  logic              sys_done,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_WT,
    S_START,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  // Value of wt_cnt while the last weight row of the tile is being pushed.
  localparam logic [7:0] WT_LAST = 8'(N - 1);

  state_t            state, state_next;
  logic [7:0]        wt_cnt, row_cnt, rows;
  logic [ADDR_W-1:0] ub_base, wt_base;
  logic              done_seen;

  // Control strobes from the next-state logic to the datapath registers.
  logic accept, wt_inc, row_inc, seen_set, seen_clr;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values and simulation order between always blocks cannot matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Command fields, counters and the sticky early-completion flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ub_base   <= '0;
      wt_base   <= '0;
      rows      <= '0;
      wt_cnt    <= '0;
      row_cnt   <= '0;
      done_seen <= 1'b0;
    end else begin
      if (accept) begin
        ub_base <= cmd_ub_addr;
        wt_base <= cmd_wt_addr;
        rows    <= cmd_rows;
        wt_cnt  <= '0;
        row_cnt <= '0;
      end else begin
        if (wt_inc)  wt_cnt  <= wt_cnt + 8'd1;
        if (row_inc) row_cnt <= row_cnt + 8'd1;
      end
      if (seen_clr)      done_seen <= 1'b0;
      else if (seen_set) done_seen <= 1'b1;
    end
  end

  // Next-state decode and all outputs; only wt_fifo_wr depends on an input directly.
  // NOTE: every signal written here gets a default first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    wt_inc     = 1'b0;
    row_inc    = 1'b0;
    seen_set   = 1'b0;
    seen_clr   = 1'b0;
    cmd_ready  = 1'b0;
    wt_rd_addr = '0;
    wt_fifo_wr = 1'b0;
    sys_start  = 1'b0;
    sys_rows   = '0;
    ub_rd_en   = 1'b0;
    ub_rd_addr = '0;
    done       = 1'b0;
    busy       = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = (cmd_rows != 8'd0) ? S_LOAD_WT : S_DONE;
        end
      end
      S_LOAD_WT: begin
        wt_rd_addr = wt_base + ADDR_W'(wt_cnt);
        wt_fifo_wr = !wt_fifo_full;
        if (!wt_fifo_full) begin
          wt_inc = 1'b1;
          if (wt_cnt == WT_LAST) state_next = S_START;
        end
      end
      S_START: begin
        sys_start  = 1'b1;
        sys_rows   = rows;
        seen_set   = sys_done;
        state_next = S_STREAM;
      end
      S_STREAM: begin
        sys_rows   = rows;
        ub_rd_en   = 1'b1;
        ub_rd_addr = ub_base + ADDR_W'(row_cnt);
        row_inc    = 1'b1;
        seen_set   = sys_done;
        if (row_cnt == rows - 8'd1) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        sys_rows = rows;
        if (sys_done || done_seen) state_next = S_DONE;
      end
      S_DONE: begin
        sys_rows   = rows;
        done       = 1'b1;
        seen_clr   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: drives directed and random commands into matmul_sequencer
// and checks every output on every cycle against a transaction-level model that
// lays out the expected cycle-by-cycle trace of each command.
module tb_matmul_sequencer;

  localparam int ADDR_W = 8;
  localparam int N      = 8;
  localparam int MAXC   = 512;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_ub_addr = '0;
  logic [ADDR_W-1:0] cmd_wt_addr = '0;
  logic [7:0]        cmd_rows = '0;
  logic [ADDR_W-1:0] wt_rd_addr;
  logic              wt_fifo_wr;
  logic              wt_fifo_full = 1'b0;
  logic              sys_start;
  logic [7:0]        sys_rows;
  logic              ub_rd_en;
  logic [ADDR_W-1:0] ub_rd_addr;
  logic              sys_done = 1'b0;
  logic              busy;
  logic              done;

  matmul_sequencer #(.ADDR_W(ADDR_W), .N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_ub_addr (cmd_ub_addr),
    .cmd_wt_addr (cmd_wt_addr),
    .cmd_rows    (cmd_rows),
    .wt_rd_addr  (wt_rd_addr),
    .wt_fifo_wr  (wt_fifo_wr),
    .wt_fifo_full(wt_fifo_full),
    .sys_start   (sys_start),
    .sys_rows    (sys_rows),
    .ub_rd_en    (ub_rd_en),
    .ub_rd_addr  (ub_rd_addr),
    .sys_done    (sys_done),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cmd_ready;
    logic       wt_fifo_wr;
    logic       sys_start;
    logic       ub_rd_en;
    logic       busy;
    logic       done;
    logic [7:0] wt_rd_addr;
    logic [7:0] sys_rows;
    logic [7:0] ub_rd_addr;
  } out_t;

  int total = 0;
  int bad   = 0;

  // Per-command stimulus, indexed by cycle number relative to acceptance (cycle 0).
  bit   full_a  [MAXC];
  bit   sdone_a [MAXC];
  out_t q[$];            // expected outputs for cycles 1..q.size()
  out_t exp_o;
  bit   chk_en = 1'b0;
  int   wr_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp_v, $time);
    end
  endtask

  function automatic out_t idle_out();
    out_t e;
    e.cmd_ready  = 1'b1;
    e.wt_fifo_wr = 1'b0;
    e.sys_start  = 1'b0;
    e.ub_rd_en   = 1'b0;
    e.busy       = 1'b0;
    e.done       = 1'b0;
    e.wt_rd_addr = '0;
    e.sys_rows   = '0;
    e.ub_rd_addr = '0;
    return e;
  endfunction

  function automatic out_t busy_out(input logic [7:0] rows_v);
    out_t e;
    e           = idle_out();
    e.cmd_ready = 1'b0;
    e.busy      = 1'b1;
    e.sys_rows  = rows_v;
    return e;
  endfunction

  // Lay out the whole expected trace of one command: N weight pushes that skip
  // full cycles, one start, one read per row, drain until completion has been
  // seen anywhere from START onwards, then one done cycle.
  task automatic build_model(input logic [7:0] ub, input logic [7:0] wt, input logic [7:0] rows_v);
    out_t e;
    int   c;
    int   w;
    bit   seen;
    q.delete();
    c = 1;
    if (rows_v != 8'd0) begin
      w = 0;
      while (w < N) begin
        e            = busy_out(8'd0);
        e.wt_rd_addr = wt + 8'(w);
        e.wt_fifo_wr = !full_a[c];
        if (!full_a[c]) w++;
        q.push_back(e);
        c++;
      end
      e           = busy_out(rows_v);
      e.sys_start = 1'b1;
      seen        = sdone_a[c];
      q.push_back(e);
      c++;
      for (int r = 0; r < int'(rows_v); r++) begin
        e            = busy_out(rows_v);
        e.ub_rd_en   = 1'b1;
        e.ub_rd_addr = ub + 8'(r);
        seen         = seen | sdone_a[c];
        q.push_back(e);
        c++;
      end
      do begin
        q.push_back(busy_out(rows_v));
        seen = seen | sdone_a[c];
        c++;
      end while (!seen && c < MAXC - 2);
    end
    e      = busy_out(rows_v);
    e.done = 1'b1;
    q.push_back(e);
  endtask

  // Single compare process: every output, every cycle, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmd_ready",  32'(cmd_ready),  32'(exp_o.cmd_ready));
      check("wt_fifo_wr", 32'(wt_fifo_wr), 32'(exp_o.wt_fifo_wr));
      check("wt_rd_addr", 32'(wt_rd_addr), 32'(exp_o.wt_rd_addr));
      check("sys_start",  32'(sys_start),  32'(exp_o.sys_start));
      check("sys_rows",   32'(sys_rows),   32'(exp_o.sys_rows));
      check("ub_rd_en",   32'(ub_rd_en),   32'(exp_o.ub_rd_en));
      check("ub_rd_addr", 32'(ub_rd_addr), 32'(exp_o.ub_rd_addr));
      check("busy",       32'(busy),       32'(exp_o.busy));
      check("done",       32'(done),       32'(exp_o.done));
      if (wt_fifo_wr === 1'b1) wr_seen++;
    end
  end

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      full_a[c]  = 1'b0;
      sdone_a[c] = (c >= 400);
    end
  endtask

  task automatic random_stim();
    for (int c = 0; c < MAXC; c++) begin
      full_a[c]  = (c < 100) && ($urandom_range(0, 3) == 0);
      sdone_a[c] = (c >= 400) || ($urandom_range(0, 9) == 0);
    end
  endtask

  // Entered at #1 after an edge with the DUT in IDLE; returns in the IDLE cycle
  // that follows DONE (or right after an abort), ready for the next command.
  task automatic run_cmd(input logic [7:0] ub, input logic [7:0] wt, input logic [7:0] rows_v,
                         input int abort_at);
    build_model(ub, wt, rows_v);
    wr_seen      = 0;
    cmd_valid    = 1'b1;
    cmd_ub_addr  = ub;
    cmd_wt_addr  = wt;
    cmd_rows     = rows_v;
    wt_fifo_full = full_a[0];
    sys_done     = sdone_a[0];
    exp_o        = idle_out();
    for (int c = 1; c <= q.size(); c++) begin
      @(posedge clk);
      #1;
      cmd_valid   = 1'($urandom_range(0, 1));
      cmd_ub_addr = 8'($urandom);
      cmd_wt_addr = 8'($urandom);
      cmd_rows    = 8'($urandom);
      if (c == abort_at) begin
        rst_n        = 1'b0;
        wt_fifo_full = 1'b0;
        sys_done     = 1'b0;
        exp_o        = idle_out();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        return;
      end
      wt_fifo_full = full_a[c];
      sys_done     = sdone_a[c];
      exp_o        = q[c-1];
    end
    @(posedge clk);
    #1;
    cmd_valid    = 1'b0;
    wt_fifo_full = 1'b0;
    sys_done     = 1'b0;
    exp_o        = idle_out();
    check("wr_count", 32'(wr_seen), (rows_v == 8'd0) ? 32'd0 : 32'(N));
  endtask

  initial begin
    // Reset state, then accept on the first edge after release.
    exp_o  = idle_out();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic: wt 0x20, ub 0x10, 9 rows, sys_done in the third DRAIN cycle.
    clear_stim();
    sdone_a[21] = 1'b1;
    run_cmd(8'h10, 8'h20, 8'd9, 0);
    check("basic_len",      32'(q.size()),          32'd22);
    check("basic_wt_last",  32'(q[7].wt_rd_addr),   32'h27);
    check("basic_start",    32'(q[8].sys_start),    32'd1);
    check("basic_sys_rows", 32'(q[8].sys_rows),     32'd9);
    check("basic_rd_first", 32'(q[9].ub_rd_addr),   32'h10);
    check("basic_rd_last",  32'(q[17].ub_rd_addr),  32'h18);
    check("basic_done",     32'(q[21].done),        32'd1);

    // FIFO full in cycles 3..5: address held at 0x22, start delayed by 3.
    clear_stim();
    full_a[3] = 1'b1;
    full_a[4] = 1'b1;
    full_a[5] = 1'b1;
    sdone_a[17] = 1'b1;
    run_cmd(8'h10, 8'h20, 8'd4, 0);
    check("bp_len",        32'(q.size()),         32'd18);
    check("bp_stall_addr", 32'(q[4].wt_rd_addr),  32'h22);
    check("bp_stall_wr",   32'(q[4].wt_fifo_wr),  32'd0);
    check("bp_start",      32'(q[11].sys_start),  32'd1);

    // rows=0 with a sys_done pulse while IDLE: done in cycle 1 only.
    clear_stim();
    sdone_a[0] = 1'b1;
    run_cmd(8'h33, 8'h44, 8'd0, 0);
    check("zero_len",  32'(q.size()), 32'd1);
    check("zero_done", 32'(q[0].done), 32'd1);

    // Early completion in the second STREAM cycle: one DRAIN cycle.
    clear_stim();
    sdone_a[11] = 1'b1;
    run_cmd(8'h00, 8'h80, 8'd5, 0);
    check("early_len", 32'(q.size()), 32'd16);

    // Unified-buffer address wrap.
    clear_stim();
    sdone_a[13] = 1'b1;
    run_cmd(8'hFE, 8'hF0, 8'd3, 0);
    check("wrap_addr", 32'(q[11].ub_rd_addr), 32'h00);

    // Reset in the middle of STREAM, then a full normal command.
    clear_stim();
    run_cmd(8'h40, 8'h00, 8'd10, 12);
    clear_stim();
    sdone_a[19] = 1'b1;
    run_cmd(8'h50, 8'h60, 8'd9, 0);

    // Random back-to-back commands.
    for (int k = 0; k < 30; k++) begin
      random_stim();
      run_cmd(8'($urandom), 8'($urandom), 8'($urandom_range(0, 20)), 0);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Command-driven sequencer for one MATMUL on the systolic array. For each accepted command it preloads one N-row weight tile into the weight FIFO, pulses the array start, and streams activation rows out of the unified buffer. It then waits for the array's completion and signals done. It sits between the instruction decode/execute stage and the systolic array, unified buffer read port, and weight FIFO write port.

## Interface
Parameters:
- ADDR_W, 8, width of unified-buffer and weight-memory addresses
- N, 8, systolic array dimension; weight rows written per command (1..255)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
- cmd_ub_addr  in  ADDR_W  unified-buffer base address of the first activation row
- cmd_wt_addr  in  ADDR_W  weight-memory base address of the tile
- cmd_rows  in  8  number of activation rows
- wt_rd_addr  out  ADDR_W  weight-memory address of the row being pushed
- wt_fifo_wr  out  1  weight FIFO write strobe
- wt_fifo_full  in  1  weight FIFO full; blocks writes
- sys_start  out  1  one-cycle start pulse to the array
- sys_rows  out  8  row count for the array
- ub_rd_en  out  1  unified-buffer read enable
- ub_rd_addr  out  ADDR_W  unified-buffer read address
- sys_done  in  1  array has finished the current matmul (pulse)
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LOAD_WT, START, STREAM, DRAIN, DONE. The state register and counters wt_cnt[7:0] and row_cnt[7:0] are registered.
- IDLE: cmd_ready=1. When cmd_valid=1, latch ub_base, wt_base and rows, and clear both counters. Go to LOAD_WT if cmd_rows≠0. If cmd_rows=0, go to DONE: no weight writes, no start, no reads.
- LOAD_WT: wt_rd_addr = wt_base + wt_cnt, mod 2^ADDR_W.
  - wt_fifo_wr = !wt_fifo_full. This is the only combinational input→output path.
  - A write occurs when wt_fifo_wr=1, and wt_cnt increments on it.
  - When full, the address is held and the state stays.
  - After the N-th write, go to START.
- START: sys_start=1 for exactly one cycle, then go to STREAM.
- STREAM: ub_rd_en=1 every cycle, with ub_rd_addr = ub_base + row_cnt, mod 2^ADDR_W.
  - row_cnt increments every cycle.
  - After the rows-th read (row_cnt = rows-1), go to DRAIN.
- DRAIN: wait for completion, then go to DONE. Completion is sys_done=1, or the done_seen flag set.
- done_seen is a sticky flag. It is set by sys_done in START or STREAM and cleared on entry to IDLE. An early sys_done is therefore never lost.
- sys_done in IDLE, LOAD_WT or DONE is ignored.
- DONE: done=1 for one cycle, then go to IDLE.
- sys_rows = latched rows in START, STREAM, DRAIN and DONE; 0 otherwise.
- ub_rd_addr = 0 and ub_rd_en = 0 outside STREAM.
- wt_rd_addr = 0 and wt_fifo_wr = 0 outside LOAD_WT.
- Command inputs are sampled only at acceptance. Later changes have no effect.

## Timing
- Reset (asynchronous assert): state=IDLE, counters, latched fields and done_seen = 0.
  - Outputs: cmd_ready=1, all other outputs 0.
  - Reset mid-operation aborts with no done pulse.
  - The first command can be accepted on the first edge after rst_n deasserts.
- Command accepted at edge 0, no FIFO stalls, rows=R≥1:
  - LOAD_WT: cycles 1..N.
  - START: cycle N+1.
  - STREAM: cycles N+2..N+1+R.
  - DRAIN: from N+2+R; minimum 1 cycle.
  - DONE: the cycle after completion is seen.
- Each full-FIFO cycle extends LOAD_WT by one cycle.
- rows=0: DONE in cycle 1, back to IDLE in cycle 2.
- Back-to-back commands: cmd_ready returns in the cycle after DONE. Minimum issue interval is N+R+4 cycles.
- Address wrap: base 0xFE with 3 rows reads 0xFE, 0xFF, 0x00 (ADDR_W=8).

## Test plan
- Basic case: N=8, cmd_wt_addr=0x20, cmd_ub_addr=0x10, rows=9, FIFO never full, sys_done 3 cycles into DRAIN.
  - Writes at wt_rd_addr 0x20..0x27 in cycles 1..8.
  - sys_start in cycle 9 with sys_rows=9.
  - Reads at ub_rd_addr 0x10..0x18 in cycles 10..18.
  - done pulse exactly once, one cycle after sys_done; cmd_ready=1 on the next cycle.
- FIFO backpressure: wt_fifo_full high in cycles 3–5.
  - wt_fifo_wr=0 and the address held at 0x22 during the stall.
  - Exactly 8 writes total; sys_start delayed by 3 cycles.
- rows=0: no wt_fifo_wr, no sys_start, no ub_rd_en; done in cycle 1.
- Early completion: sys_done asserted in the second STREAM cycle.
  - DRAIN lasts exactly 1 cycle, then done.
  - sys_done pulsed in IDLE has no effect.
- Wrap and reset:
  - ub base 0xFE, rows=3 → reads at 0xFE, 0xFF, 0x00.
  - rst_n asserted mid-STREAM → all outputs 0 and cmd_ready=1 immediately, no done pulse.
  - The next command then runs the full sequence normally.
